// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEF_*            default geometry (10-bit word address, 32 lines x 4 words)
//   cache_state_e    controller FSM states
//   num_lines()      entries addressed by an index of a given width
//   index_lsb() / tag_lsb()  bit positions of the address fields
package cache_pkg;

  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_INDEX_WIDTH  = 5;
  localparam int DEF_OFFSET_WIDTH = 2;
  localparam int DEF_TAG_WIDTH    = DEF_ADDR_WIDTH - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REFILL     = 2'd1,
    ST_WRITE_THRU = 2'd2
  } cache_state_e;

  // Number of entries addressed by an index field of the given width.
  function automatic int num_lines(input int index_width);
    return 1 << index_width;
  endfunction

  // Word address layout: {tag, index, offset}, offset in the LSBs.
  function automatic int index_lsb(input int offset_width);
    return offset_width;
  endfunction

  function automatic int tag_lsb(input int index_width, input int offset_width);
    return index_width + offset_width;
  endfunction

endpackage

// File: rtl/cache_data_array.sv
// Valid/tag/data storage for a direct-mapped cache.
// Latency: combinational read, writes take effect on the next rising edge.
// Backpressure: none; every write request is accepted.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset (clears valid bits only)
//   rd_index/rd_offset            lookup address -> rd_valid, rd_tag, rd_word
//   wr_en/wr_index/wr_offset/wr_word   single-word data write
//   fill_en/fill_index/fill_tag   tag write + valid set, marks a line as filled
module cache_data_array
  import cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [OFFSET_WIDTH-1:0] rd_offset,
  output logic                    rd_valid,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [DATA_WIDTH-1:0]   rd_word,
  input  logic                    wr_en,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [OFFSET_WIDTH-1:0] wr_offset,
  input  logic [DATA_WIDTH-1:0]   wr_word,
  input  logic                    fill_en,
  input  logic [INDEX_WIDTH-1:0]  fill_index,
  input  logic [TAG_WIDTH-1:0]    fill_tag
);

  localparam int NUM_LINES = num_lines(INDEX_WIDTH);
  localparam int NUM_WORDS = num_lines(INDEX_WIDTH + OFFSET_WIDTH);

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[{rd_index, rd_offset}];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data contents are deliberately not reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en)   data_mem[{wr_index, wr_offset}] <= wr_word;
    if (fill_en) tag_mem[fill_index]             <= fill_tag;
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between core and main memory.
// Latency: read hit 0 cycles; read miss 1 + sum of 4 ack latencies; write 1 + ack latency.
// Backpressure: stall holds the core; main memory paces every word with a one-cycle mm_ack.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_read, mem_write          load/store strobes (held while stall), addr, wdata
//   rdata, stall                 load data (valid on a read hit), core freeze
//   mm_req, mm_we, mm_addr, mm_wdata, mm_rdata, mm_ack   one-word memory handshake
//   hit_count, miss_count        saturating 16-bit counters, present only with CACHE_STATS_EN
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mm_req,
  output logic                  mm_we,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [DATA_WIDTH-1:0] mm_wdata,
  input  logic [DATA_WIDTH-1:0] mm_rdata,
  input  logic                  mm_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int TAG_W     = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int INDEX_LSB = index_lsb(OFFSET_WIDTH);
  localparam int TAG_LSB   = tag_lsb(INDEX_WIDTH, OFFSET_WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  cache_state_e            state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic                    mm_req_q, mm_req_d;
  logic                    mm_we_q, mm_we_d;
  logic [ADDR_WIDTH-1:0]   mm_addr_q, mm_addr_d;
  logic [DATA_WIDTH-1:0]   mm_wdata_q, mm_wdata_d;
  logic                    wr_done_q, wr_done_d;

  logic [ADDR_WIDTH-1:0]   lk_addr;
  logic                    arr_valid;
  logic [TAG_W-1:0]        arr_tag;
  logic [DATA_WIDTH-1:0]   arr_word;
  logic                    hit;
  logic                    wr_req, rd_req;
  logic                    arr_wr_en, fill_en;
  logic [DATA_WIDTH-1:0]   arr_wr_word;

  assign mm_req   = mm_req_q;
  assign mm_we    = mm_we_q;
  assign mm_addr  = mm_addr_q;
  assign mm_wdata = mm_wdata_q;

  // In IDLE the lookup follows the live core address; once a transaction is
  // under way it follows the latched memory address so the write-through hit
  // test and refill writes never depend on the core holding its inputs.
  assign lk_addr = (state_q == ST_IDLE) ? addr : mm_addr_q;
  assign hit     = arr_valid && (arr_tag == lk_addr[ADDR_WIDTH-1:TAG_LSB]);

  // The cycle right after a write-through ack still sees the held mem_write;
  // wr_done_q marks it as already completed so it is not issued twice.
  assign wr_req = mem_write && !wr_done_q;
  assign rd_req = mem_read && !mem_write;

  cache_data_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_W),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (lk_addr[TAG_LSB-1:INDEX_LSB]),
    .rd_offset (lk_addr[INDEX_LSB-1:0]),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_word   (arr_word),
    .wr_en     (arr_wr_en),
    .wr_index  (mm_addr_q[TAG_LSB-1:INDEX_LSB]),
    .wr_offset (mm_addr_q[INDEX_LSB-1:0]),
    .wr_word   (arr_wr_word),
    .fill_en   (fill_en),
    .fill_index(mm_addr_q[TAG_LSB-1:INDEX_LSB]),
    .fill_tag  (mm_addr_q[ADDR_WIDTH-1:TAG_LSB])
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mm_req_d    = mm_req_q;
    mm_we_d     = mm_we_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    wr_done_d   = 1'b0;
    arr_wr_en   = 1'b0;
    arr_wr_word = mm_rdata;
    fill_en     = 1'b0;
    stall       = 1'b0;
    rdata       = '0;

    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          stall      = 1'b1;
          state_d    = ST_WRITE_THRU;
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b1;
          mm_addr_d  = addr;
          mm_wdata_d = wdata;
        end else if (rd_req) begin
          if (hit) begin
            rdata = arr_word;
          end else begin
            stall     = 1'b1;
            state_d   = ST_REFILL;
            cnt_d     = '0;
            mm_req_d  = 1'b1;
            mm_we_d   = 1'b0;
            mm_addr_d = {addr[ADDR_WIDTH-1:INDEX_LSB], {OFFSET_WIDTH{1'b0}}};
          end
        end
      end

      ST_REFILL: begin
        stall = 1'b1;
        if (mm_ack) begin
          arr_wr_en   = 1'b1;
          arr_wr_word = mm_rdata;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            // Line complete: publish tag and valid together, counter wraps to 0.
            fill_en  = 1'b1;
            state_d  = ST_IDLE;
            mm_req_d = 1'b0;
          end else begin
            mm_addr_d = {mm_addr_q[ADDR_WIDTH-1:INDEX_LSB], cnt_q + 1'b1};
          end
        end
      end

      ST_WRITE_THRU: begin
        stall = 1'b1;
        if (mm_ack) begin
          // No allocate: the array only changes if the line already holds this address.
          arr_wr_en   = hit;
          arr_wr_word = mm_wdata_q;
          state_d     = ST_IDLE;
          mm_req_d    = 1'b0;
          mm_we_d     = 1'b0;
          wr_done_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mm_req_q   <= 1'b0;
      mm_we_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mm_req_q   <= mm_req_d;
      mm_we_q    <= mm_we_d;
      mm_addr_q  <= mm_addr_d;
      mm_wdata_q <= mm_wdata_d;
      wr_done_q  <= wr_done_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Sampled only on requests the IDLE state actually accepts this cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == ST_IDLE) && (wr_req || rd_req)) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: directed plan steps plus a
// randomized phase, checked against a line-level cache model and a word memory.
// Optional CACHE_STATS_EN counters are checked when the macro is defined.
module tb_data_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        mm_req;
  logic        mm_we;
  logic [9:0]  mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  int          m_hits = 0;
  int          m_misses = 0;
`endif

  always #5 clk = ~clk;

  data_cache_controller dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .mm_req   (mm_req),
    .mm_we    (mm_we),
    .mm_addr  (mm_addr),
    .mm_wdata (mm_wdata),
    .mm_rdata (mm_rdata),
    .mm_ack   (mm_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Main memory image and responder bookkeeping (responder-owned counters).
  logic [31:0] mem [1024];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          lat_sum = 0;
  logic [9:0]  rd_addr_log [$];
  logic [9:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  bit          rand_lat = 1'b0;
  int          fix_lat = 2;
  bit          inject_ack = 1'b0;

  // Reference cache model: one entry per line.
  bit          m_valid [32];
  logic [2:0]  m_tag   [32];
  logic [31:0] m_data  [32][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: each word transfer is acked after cur_lat cycles of mm_req.
  initial begin : responder
    int wait_n;
    int cur_lat;
    wait_n = 0;
    cur_lat = 1;
    mm_ack = 1'b0;
    mm_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mm_ack = 1'b0;
      if (inject_ack) begin
        mm_ack = 1'b1;
        mm_rdata = 32'hBAD0_BAD0;
      end else if (rst || !mm_req) begin
        wait_n = 0;
      end else begin
        if (wait_n == 0) cur_lat = rand_lat ? int'($urandom_range(3, 1)) : fix_lat;
        wait_n++;
        if (wait_n >= cur_lat) begin
          mm_ack = 1'b1;
          lat_sum += cur_lat;
          if (mm_we) begin
            mem[mm_addr] = mm_wdata;
            last_waddr = mm_addr;
            last_wdata = mm_wdata;
            wr_cnt++;
          end else begin
            mm_rdata = mem[mm_addr];
            rd_addr_log.push_back(mm_addr);
            rd_cnt++;
          end
          wait_n = 0;
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
`ifdef CACHE_STATS_EN
    m_hits = 0;
    m_misses = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Runs one held request until stall drops; returns stalled cycle count.
  task automatic wait_stall(output int n);
    n = 0;
    #1;
    while (stall && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_release", {31'd0, stall}, 32'd0);
  endtask

  task automatic do_read(input logic [9:0] a);
    int rs, ws, ls, n;
    logic [4:0] idx;
    logic [1:0] w;
    bit exp_hit;
    idx = a[6:2];
    exp_hit = m_valid[idx] && (m_tag[idx] == a[9:7]);
    rs = rd_cnt; ws = wr_cnt; ls = lat_sum;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read = 1'b1;
    addr = a;
    wait_stall(n);
    if (exp_hit) begin
      check("rd_hit_stall_cycles", n, 0);
      check("rd_hit_no_mem", rd_cnt - rs, 0);
`ifdef CACHE_STATS_EN
      m_hits++;
`endif
    end else begin
      check("rd_miss_words", rd_cnt - rs, 4);
      check("rd_miss_stall_cycles", n, 1 + lat_sum - ls);
      for (int i = 0; i < 4; i++) begin
        w = 2'(i);
        if (rs + i < rd_addr_log.size())
          check("refill_addr", {22'd0, rd_addr_log[rs + i]}, {22'd0, a[9:2], w});
        m_data[idx][i] = mem[{a[9:2], w}];
      end
      m_valid[idx] = 1'b1;
      m_tag[idx] = a[9:7];
`ifdef CACHE_STATS_EN
      m_misses++;
      m_hits++;
`endif
    end
    check("rd_no_write", wr_cnt - ws, 0);
    check("rdata", rdata, m_data[idx][a[1:0]]);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    int rs, ws, ls, n;
    logic [4:0] idx;
    bit exp_hit;
    idx = a[6:2];
    exp_hit = m_valid[idx] && (m_tag[idx] == a[9:7]);
    rs = rd_cnt; ws = wr_cnt; ls = lat_sum;
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b1;
    addr = a;
    wdata = d;
    wait_stall(n);
    check("wr_one_txn", wr_cnt - ws, 1);
    check("wr_stall_cycles", n, 1 + lat_sum - ls);
    check("wr_addr", {22'd0, last_waddr}, {22'd0, a});
    check("wr_data", last_wdata, d);
    check("wr_no_read", rd_cnt - rs, 0);
    if (exp_hit) m_data[idx][a[1:0]] = d;
`ifdef CACHE_STATS_EN
    if (exp_hit) m_hits++;
    else m_misses++;
`endif
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hits"}, {16'd0, hit_count}, m_hits);
    check({tag, "_misses"}, {16'd0, miss_count}, m_misses);
`else
    check({tag, "_idle_req"}, {31'd0, mm_req}, 32'd0);
`endif
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rs, n;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[10'h040 + i] = 32'hA0 + i;
    model_reset();
    rand_lat = 1'b0;
    fix_lat = 2;

    // Reset state
    do_reset();
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mm_req", {31'd0, mm_req}, 32'd0);
    check("rst_mm_we", {31'd0, mm_we}, 32'd0);
    check("rst_mm_addr", {22'd0, mm_addr}, 32'd0);
    check("rst_mm_wdata", mm_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check_stats("rst");

    // Cold miss with acks 2 cycles apart, then hits on the same line
    do_read(10'h040);
    check("plan_first_word", rdata, 32'hA0);
    do_read(10'h041);
    do_read(10'h042);
    do_read(10'h043);
    check("plan_last_word", rdata, 32'hA3);

    // Write hit updates the line; write miss does not allocate
    do_write(10'h042, 32'h0000_DEAD);
    do_read(10'h042);
    check("plan_write_hit_data", rdata, 32'h0000_DEAD);
    do_write(10'h3C0, 32'h1357_9BDF);
    do_read(10'h3C0);

    // Conflict on the same index with a different tag
    do_read(10'h140);
    do_read(10'h040);

    // Zero-wait write-through: two stalled cycles
    fix_lat = 1;
    do_write(10'h041, 32'h0BAD_F00D);
    do_read(10'h041);
    check_stats("directed");

    // Reset in the middle of a refill, then a stray ack in IDLE
    fix_lat = 2;
    rs = rd_cnt;
    @(negedge clk);
    mem_read = 1'b1;
    addr = 10'h200;
    n = 0;
    while ((rd_cnt - rs) < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_refill_two_acks", rd_cnt - rs, 2);
    @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    check("mid_rst_mm_req", {31'd0, mm_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    model_reset();
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mm_req", {31'd0, mm_req}, 32'd0);
    check_stats("after_rst");
    do_read(10'h200);
    do_read(10'h201);

    // Randomized traffic over a few lines and tags to mix hits, misses and conflicts
    rand_lat = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [9:0] a;
      a = {3'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 2'($urandom_range(3, 0))};
      if ($urandom_range(9, 0) < 3) do_write(a, $urandom);
      else do_read(a);
    end
    check_stats("final");

    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
